// File: rtl/half_interp2_if.sv
// half_interp2_if: input/output handshake bundle for the two-channel half-band interpolator
interface half_interp2_if #(parameter int dw = 16);
    logic in_valid, in_ready, in_ch, out_valid, out_ready, out_ch, out_phase, sat, ch_err;
    logic signed [dw-1:0] in_data, out_data;
    modport master(output in_valid, in_data, in_ch, out_ready,
                   input in_ready, out_valid, out_data, out_ch, out_phase, sat, ch_err);
    modport slave(input in_valid, in_data, in_ch, out_ready,
                  output in_ready, out_valid, out_data, out_ch, out_phase, sat, ch_err);
endinterface

// File: rtl/half_interp2.sv
// half_interp2: two-channel interleaved 7-tap half-band interpolator, upsample by 2
module half_interp2 #(parameter int dw = 16) (
    input logic clk,
    input logic rst,
    half_interp2_if.slave bus
);
    typedef enum logic [2:0] {WAIT_A, WAIT_B, CALC, EMIT0, EMIT1, EMIT2, EMIT3} state_t;
    localparam logic signed [dw+5:0] k9 = (dw+6)'(9);
    localparam logic signed [dw+5:0] k8 = (dw+6)'(8);
    state_t state_q, state_d;
    logic signed [dw-1:0] ha_q [4], ha_d [4], hb_q [4], hb_d [4];
    logic signed [dw-1:0] pend_q, pend_d, odd_a_q, odd_a_d, odd_b_q, odd_b_d, out_data_q, out_data_d;
    logic signed [dw-1:0] y_a, y_b;
    logic out_valid_q, out_valid_d, out_ch_q, out_ch_d, out_phase_q, out_phase_d;
    logic hs, fire, clip_a, clip_b;
    function automatic logic signed [dw+5:0] sx(input logic signed [dw-1:0] v);
        return {{6{v[dw-1]}}, v};
    endfunction
    function automatic logic signed [dw-1:0] interp(input logic signed [dw-1:0] h0, h1, h2, h3,
                                                    output logic clip);
        logic signed [dw+5:0] acc;
        acc = (k9 * (sx(h1) + sx(h2)) - sx(h0) - sx(h3) + k8) >>> 4;
        clip = acc[dw+5:dw-1] != {7{acc[dw+5]}};
        return clip ? (acc[dw+5] ? {1'b1, {(dw-1){1'b0}}} : {1'b0, {(dw-1){1'b1}}}) : acc[dw-1:0];
    endfunction
    assign bus.in_ready  = !rst && (state_q == WAIT_A || state_q == WAIT_B);
    assign hs            = bus.in_valid && bus.in_ready;
    assign fire          = bus.out_valid && bus.out_ready;
    assign bus.ch_err    = hs && (state_q == WAIT_A ? bus.in_ch : !bus.in_ch);
    assign bus.sat       = !rst && state_q == CALC && (clip_a || clip_b);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_phase = out_phase_q;
    always_comb begin
        state_d = state_q;
        ha_d = ha_q;
        hb_d = hb_q;
        pend_d = pend_q;
        odd_a_d = odd_a_q;
        odd_b_d = odd_b_q;
        y_a = interp(ha_q[0], ha_q[1], ha_q[2], ha_q[3], clip_a);
        y_b = interp(hb_q[0], hb_q[1], hb_q[2], hb_q[3], clip_b);
        case (state_q)
            WAIT_A: if (hs && !bus.in_ch) begin
                pend_d = bus.in_data;
                state_d = WAIT_B;
            end
            WAIT_B: if (hs && bus.in_ch) begin
                ha_d = '{pend_q, ha_q[0], ha_q[1], ha_q[2]};
                hb_d = '{bus.in_data, hb_q[0], hb_q[1], hb_q[2]};
                state_d = CALC;
            end else if (hs) pend_d = bus.in_data;
            CALC: begin
                odd_a_d = y_a;
                odd_b_d = y_b;
                state_d = EMIT0;
            end
            EMIT0: state_d = fire ? EMIT1 : EMIT0;
            EMIT1: state_d = fire ? EMIT2 : EMIT1;
            EMIT2: state_d = fire ? EMIT3 : EMIT2;
            EMIT3: state_d = fire ? WAIT_A : EMIT3;
            default: state_d = WAIT_A;
        endcase
        // output registers are loaded for the state being entered, so a stall reloads identical values
        out_valid_d = state_d inside {EMIT0, EMIT1, EMIT2, EMIT3};
        out_ch_d = state_d inside {EMIT1, EMIT3};
        out_phase_d = state_d inside {EMIT2, EMIT3};
        out_data_d = state_d == EMIT0 ? ha_q[2] :
                     state_d == EMIT1 ? hb_q[2] :
                     state_d == EMIT2 ? odd_a_q :
                     state_d == EMIT3 ? odd_b_q : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_A;
            ha_q <= '{default: '0};
            hb_q <= '{default: '0};
            pend_q <= '0;
            odd_a_q <= '0;
            odd_b_q <= '0;
            out_valid_q <= 1'b0;
            out_ch_q <= 1'b0;
            out_phase_q <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            ha_q <= ha_d;
            hb_q <= hb_d;
            pend_q <= pend_d;
            odd_a_q <= odd_a_d;
            odd_b_q <= odd_b_d;
            out_valid_q <= out_valid_d;
            out_ch_q <= out_ch_d;
            out_phase_q <= out_phase_d;
            out_data_q <= out_data_d;
        end
    end
endmodule

// File: tb/tb_half_interp2.sv
// tb_half_interp2: directed self-checking bench for half_interp2
module tb_half_interp2;
    logic clk = 0, rst = 1;
    int checks = 0, errors = 0, errcnt = 0, satcnt = 0;
    half_interp2_if #(.dw(16)) bus();
    half_interp2 #(.dw(16)) dut(.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (bus.ch_err === 1'b1) errcnt++;
        if (bus.sat === 1'b1) satcnt++;
    end
    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic do_reset();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask
    task automatic send(input logic ch, input logic signed [15:0] d);
        int n = 0;
        bus.in_valid = 1; bus.in_ch = ch; bus.in_data = d;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < 50) else begin
            errors++;
            $error("FAIL send_timeout: waited %0d cycles, limit 50", n);
        end
        @(posedge clk); #1;
        bus.in_valid = 0;
    endtask
    task automatic recv(input bit bp, output logic c, output logic p, output logic signed [15:0] d);
        int n = 0;
        bit done = 0, hold = 0;
        logic [17:0] prev = '0;
        c = 0; p = 0; d = 0;
        while (!done && n < 200) begin
            bus.out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                chk("in_ready_during_emit", bus.in_ready, 0);
                if (hold) chk("stall_hold", {bus.out_ch, bus.out_phase, bus.out_data}, prev);
                hold = 1;
                prev = {bus.out_ch, bus.out_phase, bus.out_data};
                if (bus.out_ready) begin
                    c = bus.out_ch; p = bus.out_phase; d = bus.out_data;
                    done = 1;
                end
            end
            n++;
            @(posedge clk); #1;
        end
        checks++;
        assert (done) else begin
            errors++;
            $error("FAIL recv_timeout: waited %0d cycles, limit 200", n);
        end
    endtask
    task automatic expect4(input bit bp, input logic signed [15:0] ae, be, ao, bo);
        logic signed [15:0] ex [4];
        logic c, p;
        logic signed [15:0] d;
        ex = '{ae, be, ao, bo};
        for (int i = 0; i < 4; i++) begin
            recv(bp, c, p, d);
            chk($sformatf("out_ch[%0d]", i), c, i % 2);
            chk($sformatf("out_phase[%0d]", i), p, i / 2);
            chk($sformatf("out_data[%0d]", i), d, ex[i]);
        end
    endtask
    task automatic pair(input logic signed [15:0] a, b, input bit bp, input logic signed [15:0] ae, be, ao, bo);
        send(0, a);
        send(1, b);
        expect4(bp, ae, be, ao, bo);
    endtask
    initial begin
        int s0;
        bus.in_valid = 0; bus.in_ch = 0; bus.in_data = 0; bus.out_ready = 0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);
        chk("post_rst_out_data", bus.out_data, 0);
        chk("post_rst_out_ch", bus.out_ch, 0);
        chk("post_rst_out_phase", bus.out_phase, 0);
        chk("post_rst_sat", bus.sat, 0);
        chk("post_rst_ch_err", bus.ch_err, 0);
        @(posedge clk); #1;
        // impulse, with first-output latency check on pair 0
        send(0, 16384);
        send(1, 0);
        @(negedge clk);
        chk("lat_calc_valid", bus.out_valid, 0);
        @(negedge clk);
        chk("lat_emit0_valid", bus.out_valid, 1);
        @(posedge clk); #1;
        expect4(0, 0, 0, -1024, 0);
        pair(0, 0, 0, 0, 0, 9216, 0);
        pair(0, 0, 0, 16384, 0, 9216, 0);
        pair(0, 0, 0, 0, 0, -1024, 0);
        pair(0, 0, 0, 0, 0, 0, 0);
        // positive DC
        do_reset();
        s0 = satcnt;
        pair(32767, 32767, 0, 0, 0, -2048, -2048);
        pair(32767, 32767, 0, 0, 0, 16384, 16384);
        pair(32767, 32767, 0, 32767, 32767, 32767, 32767);
        chk("dc_pos_transient_sat", satcnt - s0, 1);
        s0 = satcnt;
        pair(32767, 32767, 0, 32767, 32767, 32767, 32767);
        pair(32767, 32767, 0, 32767, 32767, 32767, 32767);
        chk("dc_pos_no_sat", satcnt - s0, 0);
        // negative DC
        do_reset();
        pair(-32768, -32768, 0, 0, 0, 2048, 2048);
        pair(-32768, -32768, 0, 0, 0, -16384, -16384);
        pair(-32768, -32768, 0, -32768, -32768, -32768, -32768);
        s0 = satcnt;
        pair(-32768, -32768, 0, -32768, -32768, -32768, -32768);
        pair(-32768, -32768, 0, -32768, -32768, -32768, -32768);
        chk("dc_neg_no_sat", satcnt - s0, 0);
        // saturation: a history becomes -32768, 32767, 32767, -32768
        do_reset();
        s0 = satcnt;
        pair(-32768, 0, 0, 0, 0, 2048, 0);
        pair(32767, 0, 0, 0, 0, -20480, 0);
        pair(32767, 0, 0, -32768, 0, -2048, 0);
        chk("sat_before", satcnt - s0, 0);
        pair(-32768, 0, 0, 32767, 0, 32767, 0);
        chk("sat_pulse_once", satcnt - s0, 1);
        // backpressure: impulse again with 30% out_ready
        do_reset();
        pair(16384, 0, 1, 0, 0, -1024, 0);
        pair(0, 0, 1, 0, 0, 9216, 0);
        pair(0, 0, 1, 16384, 0, 9216, 0);
        pair(0, 0, 1, 0, 0, -1024, 0);
        pair(0, 0, 1, 0, 0, 0, 0);
        // channel-order violations
        do_reset();
        s0 = errcnt;
        send(1, 5);
        chk("ch_err_first", errcnt - s0, 1);
        send(0, 100);
        send(0, 200);
        send(1, 300);
        chk("ch_err_twice", errcnt - s0, 2);
        expect4(0, 0, 0, -12, -19);
        // reset during EMIT1
        do_reset();
        send(0, 7);
        send(1, 9);
        begin
            logic c, p;
            logic signed [15:0] d;
            recv(0, c, p, d);
            chk("rst_mid_emit0", d, 0);
        end
        bus.out_ready = 0;
        do_reset();
        @(negedge clk);
        chk("rst_mid_out_valid", bus.out_valid, 0);
        chk("rst_mid_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;
        pair(1000, 1000, 0, 0, 0, -62, -62);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
